// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned MAX_REQ       = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit of a one-hot vector (0 when no bit is set).
  function automatic int unsigned onehot_idx(input logic [MAX_REQ-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning upward from pointer+1, with wrap.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N     = DEF_NUM_REQ,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     winner
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PTR_W'((32'(pointer) + k) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to keep a grant for up to BURST_LEN beats; otherwise one beat per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic                     en_w,
  output logic [WIDTH-1:0]         data_w,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  // Static parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_wr_arbiter: BURST_LEN must be at least 1");
  end

  arb_state_t         state, state_next;
  logic [NUM_REQ-1:0] grant_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [NUM_REQ-1:0] winner;
  logic               req_g;
  logic               beat;
  logic               last_beat;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] cnt, cnt_next;
`endif

  fifo_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .pointer (ptr),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PTR_W'(NUM_REQ - 1);
      busy  <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
      busy  <= (state_next == GRANT);
`ifdef FIFO_ARB_BURST_EN
      cnt   <= cnt_next;
`endif
    end
  end

  // Next-state logic plus the combinational write-port signals.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    req_g      = |(req & grant);
    beat       = 1'b0;
    last_beat  = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    cnt_next   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_next = winner;
          state_next = GRANT;
`ifdef FIFO_ARB_BURST_EN
          cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
        beat = req_g & ~full;
`ifdef FIFO_ARB_BURST_EN
        last_beat = beat && (cnt == CNT_W'(BURST_LEN - 1));
        if (beat) cnt_next = cnt + 1'b1;
`else
        last_beat = beat;
`endif
        if (!req_g || last_beat) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = PTR_W'(onehot_idx(MAX_REQ'(grant)));
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    en_w = beat;
    ack  = beat ? grant : '0;
  end

  always_comb begin
    data_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) data_w = req_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (default and FIFO_ARB_BURST_EN builds).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        full;
  logic        en_w;
  logic [3:0]  data_w;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_g;
  logic [3:0] exp_d;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (4),
    .BURST_LEN (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .en_w     (en_w),
    .data_w   (data_w),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic e,
                         input logic [3:0] a, input logic [3:0] d, input logic b);
    check({tag, ".grant"},  32'(grant),  32'(g));
    check({tag, ".en_w"},   32'(en_w),   32'(e));
    check({tag, ".ack"},    32'(ack),    32'(a));
    check({tag, ".data_w"}, 32'(data_w), 32'(d));
    check({tag, ".busy"},   32'(busy),   32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req      = 4'b0000;
    req_data = 16'hDCBA;
    full     = 1'b0;
    exp_g    = '0;
    exp_d    = '0;

    // Reset before any clock edge: outputs must clear asynchronously.
    #1 rst = 1'b1;
    #1 chk_out("reset", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    step();
    step();
    #2 rst = 1'b0;
    step();
    chk_out("idle_no_req", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);

`ifndef FIFO_ARB_BURST_EN
    // All requesting: one beat per grant, order 0,1,2,3,0,1,2,3, bubble between grants.
    req = 4'b1111;
    #1 chk_out("rr_idle", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_g = 4'(1 << (i % 4));
      exp_d = 4'hA + 4'(i % 4);
      chk_out("rr_beat", exp_g, 1'b1, exp_g, exp_d, 1'b1);
      step();
      if (i == 7) req = 4'b0000;
      #1 chk_out("rr_bubble", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    end

    // Requester 1 alone with full high: grant held, no write until full drops.
    req  = 4'b0010;
    full = 1'b1;
    step();
    chk_out("stall_grant", 4'b0010, 1'b0, 4'b0000, 4'h0, 1'b1);
    step();
    chk_out("stall_hold", 4'b0010, 1'b0, 4'b0000, 4'h0, 1'b1);
    full = 1'b0;
    #1 chk_out("stall_release", 4'b0010, 1'b1, 4'b0010, 4'hB, 1'b1);
    step();
    req = 4'b0000;
    #1 chk_out("stall_exit", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);

    // Pointer at 1: requester 2 beats requester 0; then req drop together with full.
    req = 4'b0101;
    step();
    chk_out("ptr1_pick2", 4'b0100, 1'b1, 4'b0100, 4'hC, 1'b1);
    full = 1'b1;
    req  = 4'b0001;
    #1 chk_out("drop_full", 4'b0100, 1'b0, 4'b0000, 4'h0, 1'b1);
    step();
    chk_out("drop_exit", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    step();
    chk_out("after_drop_stall", 4'b0001, 1'b0, 4'b0000, 4'h0, 1'b1);
    full = 1'b0;
    #1 chk_out("after_drop_beat", 4'b0001, 1'b1, 4'b0001, 4'hA, 1'b1);

    // Pointer at 0: requester 3 wins over 0, then wrap back to 0.
    step();
    req = 4'b1001;
    #1 chk_out("wrap_idle", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    step();
    chk_out("wrap_3", 4'b1000, 1'b1, 4'b1000, 4'hD, 1'b1);
    step();
    chk_out("wrap_bubble", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    step();
    chk_out("wrap_0", 4'b0001, 1'b1, 4'b0001, 4'hA, 1'b1);
    step();
    req = 4'b0000;
    #1 chk_out("wrap_end", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
`else
    // Bursts of 4: requester 0 then requester 2, with one full stall inside the second burst.
    req = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      step();
      exp_g = (r == 0) ? 4'b0001 : 4'b0100;
      exp_d = (r == 0) ? 4'hA : 4'hC;
      for (int b = 0; b < 4; b++) begin
        if (r == 1 && b == 1) begin
          full = 1'b1;
          #1 chk_out("burst_stall", exp_g, 1'b0, 4'b0000, 4'h0, 1'b1);
          step();
          chk_out("burst_stall_hold", exp_g, 1'b0, 4'b0000, 4'h0, 1'b1);
          full = 1'b0;
          #1;
        end
        chk_out("burst_beat", exp_g, 1'b1, exp_g, exp_d, 1'b1);
        if (b < 3) step();
      end
      step();
      if (r == 1) req = 4'b0000;
      #1 chk_out("burst_bubble", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    end
`endif

    // Reset in the middle of a grant clears outputs without a clock and restores priority 0.
    req = 4'b0100;
    step();
    chk_out("pre_rst", 4'b0100, 1'b1, 4'b0100, 4'hC, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0);
    #1 rst = 1'b0;
    req = 4'b1111;
    step();
    chk_out("post_rst", 4'b0001, 1'b1, 4'b0001, 4'hA, 1'b1);
    req = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter sharing one asynchronous FIFO write port among `NUM_REQ` requesters in the write clock domain. It grants one requester at a time, forwards that requester's data and write enable to the FIFO, and respects the FIFO `full` flag. Accepted beats are acknowledged back to the requester. Optional burst locking keeps a grant for up to `BURST_LEN` beats.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 4: data width; matches the FIFO `WIDTH`.
- `BURST_LEN`, default 4: maximum beats per grant when burst locking is compiled in; minimum 1.

**Ports**
- `clk` in, 1: write-domain clock; the same clock as the FIFO `clk_w`.
- `rst` in, 1: asynchronous, active-high reset.
- `req` in, `NUM_REQ`: per-requester write request; held high while data is pending.
- `req_data` in, `NUM_REQ*WIDTH`: requester i occupies bits [i*WIDTH +: WIDTH].
- `full` in, 1: FIFO full flag, write-domain view.
- `en_w` out, 1: FIFO write enable.
- `data_w` out, `WIDTH`: FIFO write data.
- `ack` out, `NUM_REQ`: one-hot; requester i's beat is written this cycle.
- `grant` out, `NUM_REQ`: one-hot registered grant, or all zero.
- `busy` out, 1: high when the arbiter is not in IDLE.

## Operation

**State machine**
- States are IDLE and GRANT.
- IDLE: if `req` is non-zero, the arbiter registers a one-hot `grant` for the round-robin winner, clears the beat count and moves to GRANT. Otherwise it stays in IDLE.
- GRANT, beat rule: a beat is accepted when `req[g] & ~full`. On a beat:
  - `en_w=1`
  - `ack[g]=1`
  - `data_w = req_data[g]`
  - beat count increments.
- GRANT, exit conditions: the arbiter returns to IDLE and clears `grant` at the end of a cycle in which either:
  - (a) a beat made the count equal `BURST_LEN`, or
  - (b) `req[g]` is low.
- GRANT, exit side effect: the round-robin pointer is set to g on exit.
- Full stall: if `req[g]=1` and `full=1`, the arbiter holds the grant and the count, and `en_w=0`.

**Outputs**
- `en_w`, `ack` and `data_w` are combinational from the registered `grant`, `req`, `req_data` and `full`.
- When there is no beat: `en_w=0`, `ack=0`, and `data_w=0`.

**Round-robin**
- The winner is the first requester with `req` set, scanning from pointer+1 upward with wrap modulo `NUM_REQ`.
- The pointer resets to `NUM_REQ-1`, so requester 0 has first priority.

**Widths**
- The beat counter is `$clog2(BURST_LEN+1)` bits wide and never exceeds `BURST_LEN`.

## Timing

- Arbitration latency: `req` rising in IDLE gives `grant` on the next edge. The earliest `en_w` is in that following cycle, i.e. 1 cycle from `req` to the first write.
- Release bubble: every grant release spends exactly 1 IDLE cycle before the next grant, so there is no back-to-back grant.
- Throughput: one write per cycle inside a burst while `full=0`.
- Reset values: `grant=0`, `busy=0`, `en_w=0`, `ack=0`, `data_w=0`, state IDLE, count 0, pointer `NUM_REQ-1`.
- Reset mid-burst: outputs clear immediately (asynchronous). The beat in progress is not written if `rst` asserts before the edge.
- `full` asserts on the same cycle as a beat: no write, and no ack that cycle.
- Simultaneous `req` drop and `full`: exit per rule (b); no beat.

## Configuration

- `FIFO_ARB_BURST_EN` defined: burst locking as above, up to `BURST_LEN` beats per grant.
- `FIFO_ARB_BURST_EN` undefined:
  - The effective burst length is 1, so every grant covers exactly one beat, or zero if `req` drops.
  - The `BURST_LEN` parameter is ignored and the counter is not built.
  - Round-robin rotates after every beat.

## Structure

- Shared package `fifo_arb_pkg`:
  - state enum `arb_state_t` (IDLE, GRANT)
  - function `onehot_idx` for one-hot to index conversion
  - default-parameter constants
- Sub-module `fifo_rr_pick`: combinational rotate-priority encoder with inputs `req` and `pointer` and output one-hot `winner`. It is also reusable on the read side.

## Test plan

- Reset, then `req=4'b0101` with `FIFO_ARB_BURST_EN` and `BURST_LEN=4`, all requesters holding `req`:
  - Requester 0 is granted and receives 4 acks.
  - 1 IDLE cycle follows.
  - Requester 2 is granted and receives 4 acks.
  - Then requester 0 again.
- Requester 1 alone, `full` high for 3 cycles in the middle of a burst:
  - `en_w=0` during the stall and the count holds.
  - 4 total writes with data in order.
- Requester 3 drops `req` after 2 beats:
  - Grant is released after the cycle with `req` low.
  - The pointer is 3, so requester 0 wins next.
- `rst` asserted mid-burst after 2 beats:
  - `grant`, `ack` and `en_w` go to 0 without waiting for `clk`.
  - After reset, requester 0 has priority.
- `FIFO_ARB_BURST_EN` undefined, `req=4'b1111` for 8 writes:
  - Grant order 0,1,2,3,0,1,2,3.
  - One beat per grant with a 1-cycle gap between grants.
- Integrated with the FIFO (`DEEP=16`), 4 requesters each sending 8 tagged words:
  - The read side sees 32 words.
  - Per-requester order is preserved and no word is lost.
